ppa_ks_sub_pipe: RTL and testbench

PPA_KS_SUB_PIPE -- requirements
Module: ppa_ks_sub_pipe

---
 rtl/ppa_ks_sub_pipe.sv | 120 ++++++++++++
 tb/tb_ppa_ks_sub_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ppa_ks_sub_pipe.sv
// Three-stage pipelined subtractor, D = A - B - bin, with a Kogge-Stone prefix carry network.
// Latency: 3 cycles from input transfer to out_valid; one result per cycle when unstalled.
// Backpressure: every stage loads when empty or advancing, so bubbles collapse and 3 results can wait.
module ppa_ks_sub_pipe #(
    parameter int WIDTH  = 9,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             ovf
);

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
    } pg_t;

    function automatic pg_t ks_level(input pg_t x, input int span);
        pg_t r;
        r = x;
        for (int i = span; i < WIDTH; i++) begin
            r.g[i] = x.g[i] | (x.p[i] & x.g[i-span]);
            r.p[i] = x.p[i] & x.p[i-span];
        end
        return r;
    endfunction

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] rdy;

    // Ready ripples back from the consumer; in_ready never looks at in_valid.
    assign rdy[2]    = ~vld[2] | out_ready;
    assign rdy[1]    = ~vld[1] | rdy[2];
    assign rdy[0]    = ~vld[0] | rdy[1];
    assign in_ready  = rdy[0];
    assign out_valid = vld[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            if (rdy[0]) vld[0] <= in_valid;
            if (rdy[1]) vld[1] <= vld[0];
            if (rdy[2]) vld[2] <= vld[1];
        end
    end

    // Stage 1: bitwise propagate/generate of A + ~B, carry-in is ~bin.
    logic [WIDTH-1:0] s1_p, s1_g;
    logic             s1_c0, s1_a_msb, s1_b_msb;

    always_ff @(posedge clk) begin
        if (in_valid && rdy[0]) begin
            s1_p     <= A ^ ~B;
            s1_g     <= A & ~B;
            s1_c0    <= ~bin;
            s1_a_msb <= A[WIDTH-1];
            s1_b_msb <= B[WIDTH-1];
        end
    end

    // Carry-in folds into bit 0's generate, so group G[i:0] is the carry out of bit i.
    pg_t s1_pg, s1_lvl2;

    always_comb begin
        s1_pg.p    = s1_p;
        s1_pg.g    = s1_g;
        s1_pg.g[0] = s1_g[0] | (s1_p[0] & s1_c0);
        s1_lvl2    = ks_level(ks_level(s1_pg, 1), 2);
    end

    // Stage 2: prefix spans 1 and 2 done; raw propagate kept for the sum.
    pg_t              s2_pg;
    logic [WIDTH-1:0] s2_p;
    logic             s2_c0, s2_a_msb, s2_b_msb;

    always_ff @(posedge clk) begin
        if (vld[0] && rdy[1]) begin
            s2_pg    <= s1_lvl2;
            s2_p     <= s1_p;
            s2_c0    <= s1_c0;
            s2_a_msb <= s1_a_msb;
            s2_b_msb <= s1_b_msb;
        end
    end

    pg_t              s2_fin;
    logic [WIDTH-1:0] s2_sum;

    always_comb begin
        s2_fin = s2_pg;
        for (int s = 4; s < WIDTH; s = s * 2) begin
            s2_fin = ks_level(s2_fin, s);
        end
        s2_sum = s2_p ^ {s2_fin.g[WIDTH-2:0], s2_c0};
    end

    // Stage 3: outputs reset so they read zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (vld[1] && rdy[2]) begin
            D    <= s2_sum;
            bout <= ~s2_fin.g[WIDTH-1];
            ovf  <= (s2_a_msb != s2_b_msb) && (s2_sum[WIDTH-1] != s2_a_msb);
        end
    end

endmodule

// File: tb/tb_ppa_ks_sub_pipe.sv
// Directed and randomized checks of ppa_ks_sub_pipe against a behavioural A-B-bin model.
module tb_ppa_ks_sub_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [8:0] A, B;
    logic       bin;
    logic       out_valid, out_ready;
    logic [8:0] D;
    logic       bout, ovf;

    ppa_ks_sub_pipe #(.WIDTH(9), .STAGES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    logic [10:0] q[$];
    logic        hold_pend = 1'b0;
    logic [10:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model(input logic [8:0] a, input logic [8:0] b, input logic bi);
        logic [9:0] diff;
        logic       ov;
        diff = {1'b0, a} - {1'b0, b} - {9'd0, bi};
        ov   = (a[8] != b[8]) && (diff[8] != a[8]);
        return {ov, diff[9], diff[8:0]};
    endfunction

    task automatic drive(input logic [8:0] a, input logic [8:0] b, input logic bi);
        in_valid = 1'b1;
        A = a;
        B = b;
        bin = bi;
    endtask

    // One clock: observe handshakes at the falling edge, return 1 time unit after the rising edge.
    task automatic step();
        logic [10:0] e;
        @(negedge clk);
        if (hold_pend && out_valid) chk("hold_stable", {ovf, bout, D}, held);
        hold_pend = out_valid && !out_ready;
        held = {ovf, bout, D};
        if (out_valid && out_ready) begin
            chk("result_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("result", {ovf, bout, D}, e);
            end
            pop_cnt++;
        end
        if (in_valid && in_ready) begin
            q.push_back(model(A, B, bin));
            acc_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, a0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; bin = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {ovf, bout, D}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Case 1: single transfer, exact 3-cycle latency
        drive(9'h0F5, 9'h023, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        chk("c1_not_early", out_valid, 0);
        step();
        chk("c1_out_valid", out_valid, 1);
        chk("c1_value", {ovf, bout, D}, {1'b0, 1'b0, 9'h0D2});
        step();

        // Case 2: wrap-around, signed overflow, A==B
        drive(9'h000, 9'h000, 1'b1); step();
        drive(9'h100, 9'h001, 1'b0); step();
        drive(9'h155, 9'h155, 1'b0); step();
        in_valid = 1'b0;
        chk("c2_wrap", {out_valid, ovf, bout, D}, {1'b1, 1'b0, 1'b1, 9'h1FF});
        step();
        chk("c2_ovf", {out_valid, ovf, bout, D}, {1'b1, 1'b1, 1'b0, 9'h0FF});
        step();
        chk("c2_equal", {out_valid, ovf, bout, D}, {1'b1, 1'b0, 1'b0, 9'h000});
        step(); step();

        // Case 3: 20 back-to-back operands must drain in 20 consecutive cycles
        p0 = pop_cnt;
        for (int i = 0; i < 20; i++) begin
            drive(9'($urandom), 9'($urandom), 1'($urandom));
            chk("c3_in_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        chk("c3_throughput", pop_cnt - p0, 20);
        chk("c3_drained", q.size(), 0);

        // Case 4: stall fills exactly three slots, release accepts in same cycle
        out_ready = 1'b0;
        a0 = acc_cnt; p0 = pop_cnt;
        drive(9'h1A0, 9'h05B, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            A = A + 9'd7;
        end
        chk("c4_accepted", acc_cnt - a0, 3);
        chk("c4_full", in_ready, 0);
        chk("c4_out_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("c4_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("c4_all_out", pop_cnt - p0, 4);
        chk("c4_drained", q.size(), 0);

        // Case 5: async reset with two results in flight
        out_ready = 1'b0;
        drive(9'h011, 9'h022, 1'b0); step();
        drive(9'h133, 9'h044, 1'b1); step();
        in_valid = 1'b0;
        step();
        chk("c5_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("c5_async_drop", out_valid, 0);
        chk("c5_rst_ready", in_ready, 1);
        chk("c5_rst_outputs", {ovf, bout, D}, 0);
        q.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        p0 = pop_cnt;
        for (int i = 0; i < 6; i++) step();
        chk("c5_no_stale", pop_cnt - p0, 0);

        // Case 6: random valid/ready over 10^4 cycles
        a0 = acc_cnt; p0 = pop_cnt;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            A = 9'($urandom); B = 9'($urandom); bin = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("c6_conserve", pop_cnt - p0, acc_cnt - a0);
        chk("c6_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
